// File: rtl/forward_hazard_unit_pkg.sv
// Shared forwarding-select encodings and default register address width for the
// hazard unit and the EX-stage operand muxes.
package forward_hazard_unit_pkg;
  localparam int DEF_REG_ADDR_W = 5;

  // bit1 picks the EX/MEM ALU result, bit0 picks the writeback value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MUX = 2'b01;
  localparam logic [1:0] FWD_ALU = 2'b10;
endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// One operand's forward select: compares a source register against the MEM and
// WB shadow records; the MEM (most recent) producer wins.
module fwd_select
  import forward_hazard_unit_pkg::*;
#(
  parameter int              W    = DEF_REG_ADDR_W,
  parameter logic [W-1:0]    ZERO = '0
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] mem_dst,
  input  logic         mem_we,
  input  logic [W-1:0] wb_dst,
  input  logic         wb_we,
  output logic [1:0]   sel
);
  always_comb begin
    sel = FWD_REG;
    if (mem_we && mem_dst != ZERO && mem_dst == src)
      sel = FWD_ALU;
    else if (wb_we && wb_dst != ZERO && wb_dst == src)
      sel = FWD_MUX;
  end
endmodule

// File: rtl/forward_hazard_unit.sv
// Shadow EX/MEM/WB destination tracking, operand forward selects and load-use stall.
// Optional counters are built when HAZARD_STATS_EN is defined.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRt,
  input  logic [REG_ADDR_W-1:0] idWriteReg,
  input  logic                  idRegWrite,
  input  logic                  idMemRead,
  input  logic                  flush,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stallCount,
  output logic [31:0]           fwdAluCount,
  output logic [31:0]           fwdMuxCount
`endif
);
  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
  } wb_rec_t;

  ex_rec_t ex_d, ex_q;
  wb_rec_t mem_d, mem_q, wb_d, wb_q;

  always_comb begin
    stall = idValid && ex_q.mem_read && ex_q.dst != ZERO &&
            (ex_q.dst == idRs || (idUsesRt && ex_q.dst == idRt));
    // stalled or flushed instructions leave an all-zero bubble behind
    ex_d = '0;
    if (idValid && !stall && !flush) begin
      ex_d.rs        = idRs;
      ex_d.rt        = idRt;
      ex_d.dst       = idWriteReg;
      ex_d.reg_write = idRegWrite;
      ex_d.mem_read  = idMemRead;
    end
    mem_d.dst       = ex_q.dst;
    mem_d.reg_write = ex_q.reg_write;
    wb_d            = mem_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_select #(.W(REG_ADDR_W), .ZERO(ZERO)) u_sel_a (
    .src(ex_q.rs), .mem_dst(mem_q.dst), .mem_we(mem_q.reg_write),
    .wb_dst(wb_q.dst), .wb_we(wb_q.reg_write), .sel(forwardA)
  );

  fwd_select #(.W(REG_ADDR_W), .ZERO(ZERO)) u_sel_b (
    .src(ex_q.rt), .mem_dst(mem_q.dst), .mem_we(mem_q.reg_write),
    .wb_dst(wb_q.dst), .wb_we(wb_q.reg_write), .sel(forwardB)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] alu_cnt_d, alu_cnt_q;
  logic [31:0] mux_cnt_d, mux_cnt_q;

  // one increment per cycle even when both operands forward; wraps freely
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall);
    alu_cnt_d   = alu_cnt_q + 32'(forwardA == FWD_ALU || forwardB == FWD_ALU);
    mux_cnt_d   = mux_cnt_q + 32'(forwardA == FWD_MUX || forwardB == FWD_MUX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      alu_cnt_q   <= '0;
      mux_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      alu_cnt_q   <= alu_cnt_d;
      mux_cnt_q   <= mux_cnt_d;
    end
  end

  assign stallCount  = stall_cnt_q;
  assign fwdAluCount = alu_cnt_q;
  assign fwdMuxCount = mux_cnt_q;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed checks of forward selects, load-use stall, flush and reset behaviour.
module tb_forward_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       idValid;
  logic [4:0] idRs, idRt, idWriteReg;
  logic       idUsesRt, idRegWrite, idMemRead, flush;
  logic [1:0] forwardA, forwardB;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stallCount, fwdAluCount, fwdMuxCount;
`endif

  int checks = 0;
  int errors = 0;

  forward_hazard_unit dut (
    .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRt(idUsesRt), .idWriteReg(idWriteReg), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .flush(flush), .forwardA(forwardA),
    .forwardB(forwardB), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stallCount(stallCount), .fwdAluCount(fwdAluCount), .fwdMuxCount(fwdMuxCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // v rs rt usesRt dst regWrite memRead
  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic ur, input logic [4:0] wr, input logic rw, input logic mr);
    idValid = v; idRs = rs; idRt = rt; idUsesRt = ur;
    idWriteReg = wr; idRegWrite = rw; idMemRead = mr;
    #1;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; nop(); step(); step();
    reset = 1'b0;
  endtask

  initial begin
    flush = 1'b0;
    // 1: reset with random ID inputs
    reset = 1'b1;
    id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1);
    step(); step();
    check("rst_fwdA", 32'(forwardA), 32'd0);
    check("rst_fwdB", 32'(forwardB), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0; nop(); step();
    check("rel_fwdA", 32'(forwardA), 32'd0);
`ifdef HAZARD_STATS_EN
    check("rst_stallCount", stallCount, 32'd0);
    check("rst_fwdAluCount", fwdAluCount, 32'd0);
    check("rst_fwdMuxCount", fwdMuxCount, 32'd0);
`endif

    // 2: add $3 ; sub rs=3 -> 10 / 00
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
    id(1'b1, 5'd3, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0); step();
    check("t2_fwdA", 32'(forwardA), 32'h2);
    check("t2_fwdB", 32'(forwardB), 32'h0);

    // 3: add $3 ; nop ; or rs=3 rt=3 -> 01 / 01
    nop(); step(); step();
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
    nop(); step();
    id(1'b1, 5'd3, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0); step();
    check("t3_wb_fwdA", 32'(forwardA), 32'h1);
    check("t3_wb_fwdB", 32'(forwardB), 32'h1);
    // add $3 ; add $3 ; and rs=3 -> MEM wins
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); step();
    id(1'b1, 5'd3, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0); step();
    check("t3_prio_fwdA", 32'(forwardA), 32'h2);
    check("t3_prio_fwdB", 32'(forwardB), 32'h0);

    // 4: lw $5 ; add rs=5 -> one stall cycle, then 01
    do_reset();
    id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); step();
    id(1'b1, 5'd5, 5'd6, 1'b1, 5'd11, 1'b1, 1'b0);
    check("t4_stall_on", 32'(stall), 32'd1);
    step();
    check("t4_stall_off", 32'(stall), 32'd0);
    check("t4_bubble_fwdA", 32'(forwardA), 32'h0);
    step();
    check("t4_ldu_fwdA", 32'(forwardA), 32'h1);
    check("t4_ldu_fwdB", 32'(forwardB), 32'h0);
`ifdef HAZARD_STATS_EN
    check("t4_stallCount", stallCount, 32'd1);
`endif

    // 5: writes to $0 never forward; lw $0 never stalls
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0); step();
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0); step();
    id(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0); step();
    check("t5_zero_fwdA", 32'(forwardA), 32'h0);
    check("t5_zero_fwdB", 32'(forwardB), 32'h0);
    id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); step();
    id(1'b1, 5'd0, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0);
    check("t5_zero_stall", 32'(stall), 32'd0);

    // 6: lw $7 ; consumer with flush in the stall cycle
    nop(); step(); step(); step();
    id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    id(1'b1, 5'd7, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
    flush = 1'b1; #1;
    check("t6_flush_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0; nop();
    check("t6_bubble_fwdA", 32'(forwardA), 32'h0);
    check("t6_bubble_stall", 32'(stall), 32'd0);
    // reset mid-stream with MEM matching EX.rs
    step(); step();
    id(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0); step();
    id(1'b1, 5'd9, 5'd9, 1'b1, 5'd15, 1'b1, 1'b0); step();
    check("t6_pre_fwdA", 32'(forwardA), 32'h2);
    reset = 1'b1; step();
    check("t6_rst_fwdA", 32'(forwardA), 32'h0);
    check("t6_rst_fwdB", 32'(forwardB), 32'h0);
    check("t6_rst_stall", 32'(stall), 32'd0);
    reset = 1'b0; nop(); step();
    check("t6_post_fwdA", 32'(forwardA), 32'h0);
    check("t6_post_fwdB", 32'(forwardB), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
